// File: rtl/mem_stage_sram_ctrl.sv
// mem_stage_sram_ctrl
//   MEM-stage controller for the EXE/MEM pipeline register. It turns a 32-bit
//   load or store into two half-word accesses (low, then high) to an external
//   16-bit asynchronous SRAM. While an access is in flight it holds `ready` low
//   so that the stages upstream of MEM/WB freeze.
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   mem_read_in     load request from the EXE/MEM register
//   mem_write_in    store request from the EXE/MEM register (wins if both are set)
//   alu_res_in      CPU byte address
//   val_rm_in       store data
//   ready           1 = MEM stage may advance, 0 = freeze the pipeline
//   mem_data_out    data from the last completed load (registered)
//   sram_addr       SRAM half-word address (registered)
//   sram_dq_out     SRAM write data (registered)
//   sram_dq_in      SRAM read data
//   sram_we_n       SRAM write enable, active low (registered)
//   sram_oe_n       SRAM output enable, active low (registered)
module mem_stage_sram_ctrl #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned SRAM_ADDR_W = 18,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_read_in,
  input  logic                   mem_write_in,
  input  logic [31:0]            alu_res_in,
  input  logic [31:0]            val_rm_in,
  output logic                   ready,
  output logic [31:0]            mem_data_out,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_out,
  input  logic [15:0]            sram_dq_in,
  output logic                   sram_we_n,
  output logic                   sram_oe_n
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [3:0]  CNT_LAST = 4'(WAIT_CYCLES - 1);
  localparam logic [31:0] BASE     = 32'(BASE_ADDR);

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [31:0]            addr_q, addr_d;
  logic [31:0]            data_q, data_d;
  logic [15:0]            lo_q;
  logic [31:0]            mem_data_q;
  logic [SRAM_ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [15:0]            sram_dq_q, sram_dq_d;
  logic                   we_n_q, we_n_d;
  logic                   oe_n_q, oe_n_d;
  logic                   phase_end;
  logic [31:0]            off_d;
  logic                   half_d;
  logic                   unused_off;

  assign phase_end = (cnt_q == CNT_LAST);

  // Next state, phase counter and request latching
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        cnt_d = 4'd0;
        if (mem_write_in) begin
          state_d = WR_LO;
          addr_d  = alu_res_in;
          data_d  = val_rm_in;
        end else if (mem_read_in) begin
          state_d = RD_LO;
          addr_d  = alu_res_in;
          data_d  = val_rm_in;
        end else begin
          state_d = IDLE;
        end
      end
      RD_LO, RD_HI, WR_LO, WR_HI: begin
        if (phase_end) begin
          cnt_d = 4'd0;
          case (state_q)
            RD_LO:   state_d = RD_HI;
            WR_LO:   state_d = WR_HI;
            default: state_d = DONE;
          endcase
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      // Requests seen in DONE belong to the instruction that just finished.
      DONE: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // SRAM pin values for the coming cycle, derived from the next state so the
  // registered pins line up with the state they belong to.
  always_comb begin
    off_d       = addr_d - BASE;
    half_d      = (state_d == RD_HI) || (state_d == WR_HI);
    sram_addr_d = sram_addr_q;
    sram_dq_d   = sram_dq_q;
    oe_n_d      = 1'b1;
    we_n_d      = 1'b1;
    case (state_d)
      RD_LO, RD_HI: begin
        sram_addr_d = {off_d[SRAM_ADDR_W:2], half_d};
        oe_n_d      = 1'b0;
      end
      WR_LO, WR_HI: begin
        sram_addr_d = {off_d[SRAM_ADDR_W:2], half_d};
        sram_dq_d   = half_d ? data_d[31:16] : data_d[15:0];
        // Released in the last cycle of the phase for address/data hold.
        we_n_d      = (cnt_d == CNT_LAST);
      end
      default: begin
        sram_addr_d = sram_addr_q;
      end
    endcase
  end

  // Byte-lane bits and out-of-range upper bits are intentionally dropped.
  assign unused_off = ^{off_d[31:SRAM_ADDR_W+1], off_d[1:0]};

  // State, counter, latched request, read capture and registered SRAM pins
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= 32'd0;
      data_q      <= 32'd0;
      lo_q        <= 16'd0;
      mem_data_q  <= 32'd0;
      sram_addr_q <= '0;
      sram_dq_q   <= 16'd0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      sram_addr_q <= sram_addr_d;
      sram_dq_q   <= sram_dq_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      if ((state_q == RD_LO) && phase_end) begin
        lo_q <= sram_dq_in;
      end
      // High half goes straight into the result so it is valid as DONE starts.
      if ((state_q == RD_HI) && phase_end) begin
        mem_data_q <= {sram_dq_in, lo_q};
      end
    end
  end

  assign ready = ((state_q == IDLE) && !mem_read_in && !mem_write_in) ||
                 (state_q == DONE);

  assign mem_data_out = mem_data_q;
  assign sram_addr    = sram_addr_q;
  assign sram_dq_out  = sram_dq_q;
  assign sram_we_n    = we_n_q;
  assign sram_oe_n    = oe_n_q;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// tb_mem_stage_sram_ctrl
//   Directed bench for mem_stage_sram_ctrl with a behavioural 16-bit SRAM.
//   Expected pin sequences and data are computed from the access address and
//   data in the bench itself.
module tb_mem_stage_sram_ctrl;

  localparam int WAIT = 2;

  logic        clk;
  logic        rst;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [31:0] alu_res_in;
  logic [31:0] val_rm_in;
  logic        ready;
  logic [31:0] mem_data_out;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;
  logic        sram_oe_n;

  logic [15:0] sram_mem [64];

  int n_checks = 0;
  int n_errors = 0;

  mem_stage_sram_ctrl #(
    .BASE_ADDR  (1024),
    .SRAM_ADDR_W(18),
    .WAIT_CYCLES(WAIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_read_in (mem_read_in),
    .mem_write_in(mem_write_in),
    .alu_res_in  (alu_res_in),
    .val_rm_in   (val_rm_in),
    .ready       (ready),
    .mem_data_out(mem_data_out),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_in  (sram_dq_in),
    .sram_we_n   (sram_we_n),
    .sram_oe_n   (sram_oe_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: asynchronous read while oe_n is low, write while we_n is low.
  assign sram_dq_in = sram_oe_n ? 16'h0000 : sram_mem[sram_addr[5:0]];

  always @(posedge clk) begin
    if (!sram_we_n) sram_mem[sram_addr[5:0]] <= sram_dq_out;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One complete access: request cycle, 2*WAIT busy cycles, DONE, then IDLE.
  // exp_out is the mem_data_out value expected at DONE.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_out);
    logic [31:0] off;
    logic        hi;
    int          cnt;
    off          = addr - 32'd1024;
    mem_read_in  = rd;
    mem_write_in = wr;
    alu_res_in   = addr;
    val_rm_in    = wdata;
    #1;
    check("req_ready", 32'(ready), 32'd0);
    for (int k = 0; k < 2 * WAIT; k++) begin
      tick();
      hi  = (k >= WAIT);
      cnt = k % WAIT;
      check("busy_ready", 32'(ready), 32'd0);
      check("addr", 32'(sram_addr), 32'({off[18:2], hi}));
      if (wr) begin
        check("we_n", 32'(sram_we_n), (cnt < WAIT - 1) ? 32'd0 : 32'd1);
        check("wr_oe_n", 32'(sram_oe_n), 32'd1);
        check("dq_out", 32'(sram_dq_out), hi ? 32'(wdata[31:16]) : 32'(wdata[15:0]));
      end else begin
        check("rd_oe_n", 32'(sram_oe_n), 32'd0);
        check("rd_we_n", 32'(sram_we_n), 32'd1);
      end
    end
    tick();
    check("done_ready", 32'(ready), 32'd1);
    check("done_we_n", 32'(sram_we_n), 32'd1);
    check("done_oe_n", 32'(sram_oe_n), 32'd1);
    check("done_addr_hold", 32'(sram_addr), 32'({off[18:2], 1'b1}));
    check("done_data", mem_data_out, exp_out);
    mem_read_in  = 1'b0;
    mem_write_in = 1'b0;
    tick();
    check("idle_ready", 32'(ready), 32'd1);
    check("idle_data", mem_data_out, exp_out);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) sram_mem[i] = 16'h0000;
    rst          = 1'b1;
    mem_read_in  = 1'b0;
    mem_write_in = 1'b0;
    alu_res_in   = 32'd0;
    val_rm_in    = 32'd0;

    // 1. reset state
    tick();
    tick();
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_oe_n", 32'(sram_oe_n), 32'd1);
    check("rst_data", mem_data_out, 32'd0);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_dq", 32'(sram_dq_out), 32'd0);
    rst = 1'b0;
    tick();
    tick();
    check("quiet_ready", 32'(ready), 32'd1);
    check("quiet_oe_n", 32'(sram_oe_n), 32'd1);

    // 2. store 0xDEADBEEF at 1032 -> half-words 4 and 5
    access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 32'd0);
    check("mem4", 32'(sram_mem[4]), 32'h0000BEEF);
    check("mem5", 32'(sram_mem[5]), 32'h0000DEAD);

    // 3. load it back
    access(1'b1, 1'b0, 32'd1032, 32'd0, 32'hDEADBEEF);

    // 4. store then immediately load at 1024
    access(1'b0, 1'b1, 32'd1024, 32'h12345678, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'd1024, 32'd0, 32'h12345678);
    check("mem0", 32'(sram_mem[0]), 32'h00005678);
    check("mem1", 32'(sram_mem[1]), 32'h00001234);
    check("mem4_kept", 32'(sram_mem[4]), 32'h0000BEEF);
    check("mem5_kept", 32'(sram_mem[5]), 32'h0000DEAD);

    // 5. both strobes set: write wins, load result untouched
    sram_mem[9] = 16'h7777;
    access(1'b1, 1'b1, 32'd1040, 32'h0000A5A5, 32'h12345678);
    check("mem8", 32'(sram_mem[8]), 32'h0000A5A5);
    check("mem9", 32'(sram_mem[9]), 32'h00000000);

    // 6. reset during RD_HI abandons the load
    mem_read_in = 1'b1;
    alu_res_in  = 32'd1032;
    for (int k = 0; k < WAIT + 1; k++) tick();
    check("pre_rst_oe_n", 32'(sram_oe_n), 32'd0);
    check("pre_rst_addr", 32'(sram_addr), 32'd5);
    rst         = 1'b1;
    mem_read_in = 1'b0;
    tick();
    check("mid_rst_oe_n", 32'(sram_oe_n), 32'd1);
    check("mid_rst_ready", 32'(ready), 32'd1);
    check("mid_rst_data", mem_data_out, 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_ready", 32'(ready), 32'd1);
    access(1'b1, 1'b0, 32'd1032, 32'd0, 32'hDEADBEEF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
